// File: rtl/ahb_arbiter_if.sv
// Bus-side signals of the AHB arbiter: manager requests, muxed transfer control,
// and the grant/owner outputs consumed by the fabric multiplexers.
interface ahb_arbiter_if #(
  parameter int N_MGR = 4,
  parameter int MW    = $clog2(N_MGR + 1)
);
  logic [N_MGR-1:0] i_hbusreq;
  logic [N_MGR-1:0] i_hsplit;
  logic [1:0]       i_htrans;
  logic [2:0]       i_hburst;
  logic             i_hready;
  logic [1:0]       i_hresp;
  logic [N_MGR-1:0] o_hgrant;
  logic [MW-1:0]    o_hmaster;
  logic [MW-1:0]    o_hmaster_d;
  logic             o_dummy;
  logic [N_MGR-1:0] o_split_mask;

  // Arbiter side
  modport master (
    input  i_hbusreq, i_hsplit, i_htrans, i_hburst, i_hready, i_hresp,
    output o_hgrant, o_hmaster, o_hmaster_d, o_dummy, o_split_mask
  );

  // Fabric / manager side
  modport slave (
    output i_hbusreq, i_hsplit, i_htrans, i_hburst, i_hready, i_hresp,
    input  o_hgrant, o_hmaster, o_hmaster_d, o_dummy, o_split_mask
  );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter with fixed-burst locking, SPLIT masking and a
// grant -> address owner -> data owner pipeline advanced on HREADY.
module ahb_arbiter #(
  parameter int  N_MGR  = 4,
  parameter int  P_DFLT = 0,
  localparam int MW     = $clog2(N_MGR + 1)
) (
  input  logic          i_hclk,
  input  logic          i_hreset_n,
  ahb_arbiter_if.master bus
);

  localparam logic [1:0] TRANS_IDLE   = 2'd0;
  localparam logic [1:0] TRANS_NONSEQ = 2'd2;
  localparam logic [1:0] TRANS_SEQ    = 2'd3;
  localparam logic [1:0] RESP_OKAY    = 2'd0;
  localparam logic [1:0] RESP_SPLIT   = 2'd2;
  localparam int         PADW         = 2 ** MW;

  localparam logic [MW-1:0]    DUMMY   = MW'(N_MGR);
  localparam logic [MW-1:0]    P_IDX   = MW'(P_DFLT);
  localparam logic [N_MGR-1:0] GNT_RST = N_MGR'(1) << P_DFLT;

  logic [4:0]       rem_q, rem_d;
  logic [MW-1:0]    ptr_q, ptr_d;
  logic [N_MGR-1:0] hgrant_q, hgrant_d;
  logic [MW-1:0]    addr_own_q, addr_own_d;
  logic [MW-1:0]    data_own_q, data_own_d;
  logic [N_MGR-1:0] split_mask_q, split_mask_d;

  logic             acc;
  logic             fixed_burst;
  logic [4:0]       burst_load;
  logic             locked;
  logic [N_MGR-1:0] elig;
  logic [PADW-1:0]  elig_pad;
  logic             rr_found;
  logic [MW-1:0]    rr_idx;
  logic [MW:0]      cand;
  logic             win_valid;
  logic [MW-1:0]    win_idx;
  logic [N_MGR-1:0] win_onehot;
  logic [MW-1:0]    gnt_idx;
  logic             split_set;
  logic [N_MGR-1:0] split_hit;

  assign acc = bus.i_hready & ((bus.i_htrans == TRANS_NONSEQ) | (bus.i_htrans == TRANS_SEQ));

  always_comb begin
    fixed_burst = 1'b1;
    burst_load  = 5'd0;
    case (bus.i_hburst)
      3'd3:    burst_load = 5'd3;
      3'd5:    burst_load = 5'd7;
      3'd7:    burst_load = 5'd15;
      default: fixed_burst = 1'b0;
    endcase
  end

  // Beats still to come of the current fixed burst; an error/split response aborts it.
  always_comb begin
    rem_d = rem_q;
    if (!bus.i_hready) begin
      if (bus.i_hresp != RESP_OKAY) rem_d = 5'd0;
    end else if (acc) begin
      if (bus.i_htrans == TRANS_NONSEQ) rem_d = fixed_burst ? burst_load : 5'd0;
      else if (rem_q != 5'd0)           rem_d = rem_q - 5'd1;
    end else if (bus.i_htrans == TRANS_IDLE) begin
      rem_d = 5'd0;
    end
  end

  // Unlocking at rem==2 lets the grant move on the penultimate beat, so the
  // new owner's NONSEQ follows the last beat with no gap.
  assign locked = (rem_q > 5'd2) | ((bus.i_htrans == TRANS_NONSEQ) & fixed_burst);

  assign elig     = bus.i_hbusreq & ~split_mask_q;
  assign elig_pad = PADW'(elig);

  always_comb begin
    rr_found = 1'b0;
    rr_idx   = P_IDX;
    cand     = '0;
    for (int k = 1; k <= N_MGR; k++) begin
      cand = {1'b0, ptr_q} + (MW+1)'(k);
      if (cand >= (MW+1)'(N_MGR)) cand = cand - (MW+1)'(N_MGR);
      if (!rr_found && elig_pad[cand[MW-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = cand[MW-1:0];
      end
    end
  end

  assign win_valid = rr_found | ~split_mask_q[P_DFLT];
  assign win_idx   = rr_found ? rr_idx : P_IDX;
  assign split_set = (bus.i_hresp == RESP_SPLIT) & ~bus.i_hready & (data_own_q != DUMMY);

  genvar gi;
  generate
    for (gi = 0; gi < N_MGR; gi++) begin : g_mgr
      assign win_onehot[gi] = win_valid & (win_idx == MW'(gi));
      assign split_hit[gi]  = split_set & (data_own_q == MW'(gi));
    end
  endgenerate

  always_comb begin
    gnt_idx = DUMMY;
    for (int i = 0; i < N_MGR; i++) begin
      if (hgrant_q[i]) gnt_idx = MW'(i);
    end
  end

  // A new SPLIT on a manager wins over a simultaneous resume for the same bit.
  assign split_mask_d = (split_mask_q & ~bus.i_hsplit) | split_hit;

  always_comb begin
    hgrant_d   = hgrant_q;
    ptr_d      = ptr_q;
    addr_own_d = addr_own_q;
    data_own_d = data_own_q;
    if (bus.i_hready) begin
      addr_own_d = gnt_idx;
      data_own_d = addr_own_q;
      if (!locked) begin
        hgrant_d = win_onehot;
        if (rr_found) ptr_d = rr_idx;
      end
    end
  end

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      rem_q        <= 5'd0;
      ptr_q        <= P_IDX;
      hgrant_q     <= GNT_RST;
      addr_own_q   <= P_IDX;
      data_own_q   <= P_IDX;
      split_mask_q <= '0;
    end else begin
      rem_q        <= rem_d;
      ptr_q        <= ptr_d;
      hgrant_q     <= hgrant_d;
      addr_own_q   <= addr_own_d;
      data_own_q   <= data_own_d;
      split_mask_q <= split_mask_d;
    end
  end

  assign bus.o_hgrant     = hgrant_q;
  assign bus.o_hmaster    = addr_own_q;
  assign bus.o_hmaster_d  = data_own_q;
  assign bus.o_dummy      = (addr_own_q == DUMMY);
  assign bus.o_split_mask = split_mask_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed scenarios plus randomized traffic, every cycle compared against a
// cycle-level behavioural model of the arbitration rules.
module tb_ahb_arbiter;
  localparam int N  = 4;
  localparam int PD = 0;
  localparam int MW = $clog2(N + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ahb_arbiter_if #(.N_MGR(N)) bus ();

  ahb_arbiter #(.N_MGR(N), .P_DFLT(PD)) dut (
    .i_hclk     (clk),
    .i_hreset_n (rst_n),
    .bus        (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: -1 for "no grant", N for the dummy owner
  int       m_rem, m_ptr, m_gnt, m_own, m_down;
  bit [N-1:0] m_mask;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic [N-1:0] req, input logic [1:0] trans, input logic [2:0] burst,
                       input logic ready, input logic [1:0] resp, input logic [N-1:0] split);
    bus.i_hbusreq = req;
    bus.i_htrans  = trans;
    bus.i_hburst  = burst;
    bus.i_hready  = ready;
    bus.i_hresp   = resp;
    bus.i_hsplit  = split;
  endtask

  task automatic model_reset();
    m_rem = 0; m_ptr = PD; m_gnt = PD; m_own = PD; m_down = PD; m_mask = '0;
  endtask

  task automatic model_step();
    int blen, nrem, win, c;
    bit lock;
    bit [N-1:0] nmask;
    case (bus.i_hburst)
      3'd3: blen = 4;
      3'd5: blen = 8;
      3'd7: blen = 16;
      default: blen = 0;
    endcase
    lock = (m_rem > 2) || (bus.i_htrans == 2 && blen != 0);
    nrem = m_rem;
    if (!bus.i_hready) begin
      if (bus.i_hresp != 0) nrem = 0;
    end else if (bus.i_htrans == 2) nrem = (blen != 0) ? blen - 1 : 0;
    else if (bus.i_htrans == 3) nrem = (m_rem > 0) ? m_rem - 1 : 0;
    else if (bus.i_htrans == 0) nrem = 0;
    win = -1;
    for (int k = 1; k <= N; k++) begin
      c = (m_ptr + k) % N;
      if (win < 0 && bus.i_hbusreq[c] && !m_mask[c]) win = c;
    end
    nmask = m_mask & ~bus.i_hsplit;
    if (bus.i_hresp == 2 && !bus.i_hready && m_down != N) nmask[m_down] = 1'b1;
    if (bus.i_hready) begin
      m_down = m_own;
      m_own  = (m_gnt < 0) ? N : m_gnt;
      if (!lock) begin
        if (win >= 0) begin
          m_gnt = win;
          m_ptr = win;
        end else begin
          m_gnt = m_mask[PD] ? -1 : PD;
        end
      end
    end
    m_mask = nmask;
    m_rem  = nrem;
  endtask

  task automatic compare_all(input string tag);
    check_val({tag, "_gnt"},  32'(bus.o_hgrant),     (m_gnt < 0) ? 32'd0 : (32'd1 << m_gnt));
    check_val({tag, "_mst"},  32'(bus.o_hmaster),    32'(m_own));
    check_val({tag, "_mstd"}, 32'(bus.o_hmaster_d),  32'(m_down));
    check_val({tag, "_dmy"},  32'(bus.o_dummy),      32'(m_own == N));
    check_val({tag, "_msk"},  32'(bus.o_split_mask), 32'(m_mask));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    model_step();
    compare_all(tag);
  endtask

  bit [2:0] burst_tab [5] = '{3'd0, 3'd1, 3'd3, 3'd5, 3'd7};
  int  stim_left;
  logic [2:0] cur_burst;
  logic [1:0] tr;

  initial begin
    drive('0, 2'd0, 3'd0, 1'b1, 2'd0, '0);
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    compare_all("rst");
    rst_n = 1'b1;

    // Reset and idle
    for (int i = 0; i < 10; i++) tick("t1");
    check_val("t1_gnt_idle", 32'(bus.o_hgrant), 32'h1);
    check_val("t1_mst_idle", 32'(bus.o_hmaster), 32'd0);
    $display("t1 idle: grant %b hmaster %0d dummy %0b", bus.o_hgrant, bus.o_hmaster, bus.o_dummy);

    // Round robin with all requesting
    begin
      int exp_g [5] = '{2, 4, 8, 1, 2};
      int exp_m [5] = '{0, 1, 2, 3, 0};
      drive(4'b1111, 2'd2, 3'd0, 1'b1, 2'd0, '0);
      for (int i = 0; i < 5; i++) begin
        tick("t2");
        check_val("t2_rr_gnt", 32'(bus.o_hgrant), 32'(exp_g[i]));
        check_val("t2_rr_mst", 32'(bus.o_hmaster), 32'(exp_m[i]));
        $display("t2 edge %0d: grant %b hmaster %0d", i + 1, bus.o_hgrant, bus.o_hmaster);
      end
    end

    // INCR8 lock with M1 waiting
    drive(4'b0001, 2'd0, 3'd0, 1'b1, 2'd0, '0);
    repeat (3) tick("t3s");
    for (int b = 1; b <= 8; b++) begin
      drive((b >= 7) ? 4'b0010 : 4'b0011, (b == 1) ? 2'd2 : 2'd3, 3'd5, 1'b1, 2'd0, '0);
      tick("t3");
      check_val("t3_lock_gnt", 32'(bus.o_hgrant), (b <= 6) ? 32'h1 : 32'h2);
      $display("t3 beat %0d: grant %b hmaster %0d", b, bus.o_hgrant, bus.o_hmaster);
    end
    check_val("t3_handover_mst", 32'(bus.o_hmaster), 32'd1);
    drive(4'b0010, 2'd2, 3'd0, 1'b1, 2'd0, '0);
    tick("t3n");

    // SPLIT of M2 in the data phase
    drive(4'b0100, 2'd0, 3'd0, 1'b1, 2'd0, '0);
    repeat (3) tick("t5s");
    drive(4'b1100, 2'd0, 3'd0, 1'b0, 2'd2, '0);
    tick("t5a");
    check_val("t5_mask_set", 32'(bus.o_split_mask), 32'h4);
    drive(4'b1100, 2'd0, 3'd0, 1'b1, 2'd2, '0);
    tick("t5b");
    check_val("t5_gnt_m3", 32'(bus.o_hgrant), 32'h8);
    drive(4'b1100, 2'd0, 3'd0, 1'b1, 2'd0, 4'b0100);
    tick("t5c");
    check_val("t5_mask_clr", 32'(bus.o_split_mask), 32'h0);
    drive(4'b1100, 2'd0, 3'd0, 1'b1, 2'd0, '0);
    tick("t5d");
    check_val("t5_regrant_m2", 32'(bus.o_hgrant), 32'h4);
    $display("t5 split: grant %b mask %b", bus.o_hgrant, bus.o_split_mask);

    // All requesters split, including the default manager
    drive(4'b0001, 2'd0, 3'd0, 1'b1, 2'd0, '0);
    repeat (3) tick("t6s");
    drive(4'b0001, 2'd0, 3'd0, 1'b0, 2'd2, '0);
    tick("t6a");
    drive(4'b0010, 2'd0, 3'd0, 1'b1, 2'd0, '0);
    repeat (3) tick("t6b");
    drive(4'b0011, 2'd0, 3'd0, 1'b0, 2'd2, 4'b0010);
    tick("t6c");
    check_val("t6_set_wins", 32'(bus.o_split_mask), 32'h3);
    drive(4'b0011, 2'd0, 3'd0, 1'b1, 2'd0, '0);
    tick("t6d");
    check_val("t6_no_gnt", 32'(bus.o_hgrant), 32'h0);
    tick("t6e");
    check_val("t6_dummy_mst", 32'(bus.o_hmaster), 32'(N));
    check_val("t6_dummy", 32'(bus.o_dummy), 32'd1);
    drive(4'b0011, 2'd0, 3'd0, 1'b0, 2'd2, '0);
    repeat (2) tick("t6f");
    drive('0, 2'd0, 3'd0, 1'b1, 2'd0, 4'b0011);
    tick("t6g");
    $display("t6 all split: grant %b hmaster %0d dummy %0b", bus.o_hgrant, bus.o_hmaster, bus.o_dummy);

    // Randomized traffic with burst-shaped transfers and one asynchronous reset
    stim_left = 0;
    cur_burst = 3'd0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (stim_left > 0) begin
        tr = ($urandom_range(0, 5) == 0) ? 2'd1 : 2'd3;
        if (tr == 2'd3) stim_left--;
      end else begin
        cur_burst = burst_tab[$urandom_range(0, 4)];
        tr = 2'($urandom_range(0, 3));
        if (tr == 2'd2) stim_left = (cur_burst == 3'd3) ? 3 : (cur_burst == 3'd5) ? 7 :
                                    (cur_burst == 3'd7) ? 15 : 0;
      end
      drive(N'($urandom), tr, cur_burst, ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 11) == 0) ? 2'($urandom) : 2'd0,
            ($urandom_range(0, 5) == 0) ? N'($urandom) : '0);
      tick("rnd");
      if (cyc == 750) begin
        rst_n = 1'b0;
        #2;
        model_reset();
        compare_all("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        $display("rnd: asynchronous reset applied at cycle %0d", cyc);
      end
      if (cyc % 250 == 249) $display("rnd: %0d cycles, grant %b mask %b", cyc + 1, bus.o_hgrant, bus.o_split_mask);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Round-robin AHB bus arbiter that shares one AHB subordinate fabric between up to N `ahb_manager` instances. It drives each manager's `i_hgrant` from their `o_hbusreq`, and drives the address-phase and data-phase owner indices used by the bus multiplexers. It keeps fixed-length bursts (INCR4/8/16) intact, hands over with zero dead cycles, and masks SPLIT managers until the subordinate releases them.

## Interface
- `N_MGR`, default 4: number of managers, range 2..16.
- `P_DFLT`, default 0: default manager, granted when nothing is requested.
- `MW`, derived as `$clog2(N_MGR+1)`: owner index width. Value `N_MGR` denotes the dummy owner.
- `i_hclk` (in, 1): clock.
- `i_hreset_n` (in, 1): reset, asynchronous, active-low.
- `i_hbusreq` (in, N_MGR): per-manager bus request.
- `i_hsplit` (in, N_MGR): subordinate split-resume, one bit per manager.
- `i_htrans` (in, 2): muxed HTRANS of the current address owner. Encoding: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `i_hburst` (in, 3): muxed HBURST. Encoding: SINGLE=0, INCR=1, INCR4=3, INCR8=5, INCR16=7.
- `i_hready` (in, 1): bus HREADY.
- `i_hresp` (in, 2): bus HRESP. Encoding: OKAY=0, ERROR=1, SPLIT=2, RETRY=3.
- `o_hgrant` (out, N_MGR): one-hot or all-zero grant.
- `o_hmaster` (out, MW): address-phase owner index.
- `o_hmaster_d` (out, MW): data-phase owner index.
- `o_dummy` (out, 1): no real owner. The address mux must drive IDLE.
- `o_split_mask` (out, N_MGR): managers currently parked by SPLIT.

## Operation
**Beat accept**
- `acc = i_hready & (i_htrans == NONSEQ | i_htrans == SEQ)`.

**Burst tracker**
- `rem` is 5 bits and counts the beats of the current fixed burst not yet accepted, including the one on the bus.
- Accepted NONSEQ with INCR4/8/16: `rem` loads 3/7/15.
- Accepted SEQ with `rem != 0`: `rem` decrements.
- BUSY: `rem` holds.
- IDLE or NONSEQ of SINGLE/INCR with `i_hready=1`: `rem` clears.
- First response cycle (`i_hready=0`, `i_hresp != OKAY`): `rem` clears (early termination).

**Lock**
- `locked = (rem > 2) | (i_htrans == NONSEQ & i_hburst ∈ {INCR4, INCR8, INCR16})`.
- Only fixed bursts lock. INCR and SINGLE may be re-arbitrated on any accepted beat.

**Split mask**
- Set bit `o_hmaster_d` when `i_hresp == SPLIT & ~i_hready` and `o_hmaster_d != N_MGR`.
- Clear bits where `i_hsplit=1`.
- If set and clear hit the same bit in the same cycle, set wins.

**Eligibility**
- `elig = i_hbusreq & ~o_split_mask`.

**Arbitration**
- Evaluated every cycle, committed only on `i_hready=1 & ~locked`.
- Round robin: search starts at `ptr+1` and wraps modulo N_MGR. The first `elig` bit wins.
- `ptr` updates to the winner only when a real request won.
- `elig == 0`: grant `P_DFLT` if it is not masked. Otherwise grant nothing: `o_hgrant = 0`, next owner = N_MGR.
- The current owner keeps the grant if it is the RR winner. No preference is given otherwise; RETRY does not give the owner priority.

**Ownership pipeline (all on `i_hready=1` edges)**
- `o_hgrant` receives the arbitration result.
- `o_hmaster` receives the index of the previous `o_hgrant` (N_MGR if all-zero).
- `o_hmaster_d` receives `o_hmaster`.
- `o_dummy = (o_hmaster == N_MGR)`, combinational from the register.

**Hold**
- All state holds while `i_hready=0`, except `rem` clear and mask set/clear.

## Timing
**Reset values**
- `o_hgrant = 1 << P_DFLT`.
- `o_hmaster = o_hmaster_d = P_DFLT`.
- `o_dummy = 0`, `o_split_mask = 0`.
- `rem = 0`, `ptr = P_DFLT`.
- Reset mid-burst aborts the burst immediately and returns to these values. No partial state survives.

**Latencies**
- Request to grant: 1 `i_hready` edge after `i_hbusreq` is sampled with the arbiter unlocked.
- Grant to address ownership: next `i_hready` edge. Address to data ownership: next `i_hready` edge.
- INCR4 handover: grant changes on the edge accepting beat 3 and `o_hmaster` changes on the edge accepting beat 4. The new owner's NONSEQ lands in the cycle after beat 4 with zero dead cycles.
- SPLIT: the mask is set at the end of response cycle 1 and arbitration excludes the manager at the response cycle 2 edge (`i_hready=1`).
- `i_hsplit` pulse: the mask bit clears on the next edge and the manager is eligible from the following cycle.
- Wait states stall all pipeline registers. `o_hgrant` never changes while `i_hready=0`.

**Width rules**
- `rem` saturates at 0 and never underflows (a SEQ with `rem=0` is ignored).
- `ptr` arithmetic is modulo N_MGR.

## Test plan
1. **Reset and idle.** Hold reset, release with `i_hbusreq=0`, `P_DFLT=0`. Required: `o_hgrant=4'b0001`, `o_hmaster=0`, `o_dummy=0`, stable for 10 cycles.
2. **Round-robin fairness.** `i_hbusreq=4'b1111`, SINGLE NONSEQ every cycle, `i_hready=1`. Required: grant sequence 1,2,3,0,1 (one-hot) and `o_hmaster` trails the grant by one edge.
3. **INCR8 lock.** M0 issues NONSEQ INCR8 followed by 7 SEQ while M1 requests. Required: `o_hgrant` stays M0 through the edge accepting beat 6, switches to M1 at beat 7, `o_hmaster=1` after beat 8, and no IDLE gap.
4. **Wait states and BUSY mid-burst.** M0 INCR4 with 3 wait cycles on beat 2 and one BUSY. Required: `rem` holds through waits and BUSY, and handover still occurs at beat 3/4.
5. **SPLIT flow.** M2 in the data phase gets SPLIT (2 cycles) while M2 and M3 request. Required: `o_split_mask=4'b0100`, grant goes to M3. `i_hsplit[2]` pulse clears the mask and M2 is regranted by RR order.
6. **All split.** Mask M0 (`P_DFLT`) and M1 with only M0 and M1 requesting. Required: `o_hgrant=0`, then `o_hmaster=N_MGR` and `o_dummy=1`. A same-cycle SPLIT set and `i_hsplit` on one bit leaves the bit set.
